p18_spi_host: RTL and testbench
===============================

# p18_spi_host

SPI master that drives the breakout game's SPI slave port (sck/ss/mosi in, miso out) from a test controller or companion FPGA design. It frames transactions on `ss`, shifts 16-bit command words out MSB-first on `mosi`, and captures the first `STATE_SIZE` bits returned on `miso` as a game-state snapshot. It sits between a word-producing controller (valid/ready) and the four SPI pins.

## Interface
Parameters:
- `CLK_DIV`, default 4: `clk` cycles per sck half-period. Legal range is 2 or more. The breakout slave requires at least 4 because of its input synchronizers.
- `WORD_WIDTH`, default 16: bits per command word.
- `STATE_SIZE`, default 21: number of leading miso bits captured as state.

Ports:
- `clk` input, 1: single system clock.
- `nRst` input, 1: reset, asynchronous and active-low.
- `start` input, 1: one-cycle request to open a transaction. Ignored while `busy`=1.
- `word_valid` input, 1: `word` and `word_last` are valid.
- `word` input, WORD_WIDTH: command word to shift out.
- `word_last` input, 1: this word ends the transaction.
- `word_ready` output, 1: high only in FETCH. A word is accepted when `word_valid` and `word_ready` are both high.
- `busy` output, 1: high in every state except IDLE.
- `state_out` output, STATE_SIZE: last captured snapshot. The first sampled bit lands in the MSB.
- `state_valid` output, 1: one-cycle pulse when `state_out` updates.
- `sck` output, 1: SPI clock, idles low (mode 0).
- `ss` output, 1: slave select, active low.
- `mosi` output, 1: serial data out.
- `miso` input, 1: serial data in.

## Operation
The FSM has seven states: IDLE, ASSERT, FETCH, LOW, HIGH, RELEASE, GAP.

- **IDLE**: `ss`=1, `sck`=0, `mosi`=0. `start` moves to ASSERT. The capture counter clears on entry to ASSERT.
- **ASSERT**: `ss`=0 for CLK_DIV cycles, then go to FETCH.
- **FETCH**: `word_ready`=1 and `sck`=0.
  - On handshake: load the shift register, set `bit_cnt`=WORD_WIDTH-1, latch `word_last`, go to LOW.
  - With no handshake, stall indefinitely with `ss` held low.
- **LOW**: `sck`=0 and `mosi`=shift[MSB] for CLK_DIV cycles, then go to HIGH.
- **HIGH**: `sck`=1 for CLK_DIV cycles.
  - `miso` is sampled in the last HIGH cycle. While the capture count is below STATE_SIZE, the sample shifts into the capture register and the count increments; later bits are discarded. The count saturates at STATE_SIZE.
  - At the end of HIGH: if `bit_cnt`≠0, shift left, decrement `bit_cnt`, go to LOW. If `bit_cnt`=0 and the latched last flag is set, go to RELEASE. Otherwise go to FETCH.
- **RELEASE**: `sck`=0 and `ss`=0 for CLK_DIV cycles, then go to GAP.
  - On leaving RELEASE, if the count equals STATE_SIZE, copy the capture register to `state_out` and pulse `state_valid`.
  - If the transaction shifted fewer than STATE_SIZE bits (for example, one word), `state_out` is unchanged and there is no pulse.
- **GAP**: `ss`=1 for CLK_DIV cycles (minimum deselect time), then go to IDLE.

Boundary rules:
- `start` arriving together with the IDLE→ASSERT transition cycle of a prior GAP exit is not accepted; only IDLE samples `start`.
- `word_valid` outside FETCH has no effect.
- An asynchronous reset mid-transaction immediately forces `ss`=1, `sck`=0, `mosi`=0 and state IDLE, and leaves `state_out` at 0. The slave sees an aborted frame.

## Timing
- Reset values: `ss`=1, `sck`=0, `mosi`=0, `busy`=0, `word_ready`=0, `state_valid`=0, `state_out`=0, FSM=IDLE.
- Outputs are registered or decoded directly from FSM state. There is no combinational path from `miso`.
- One bit takes 2·CLK_DIV cycles. Each word boundary adds one FETCH cycle with `sck` low, provided `word_valid` is already high.
- Transaction length with n words and no stalls, measured from the `start` cycle to the return to IDLE: 1 + CLK_DIV + n·(1+2·CLK_DIV·WORD_WIDTH) + 2·CLK_DIV cycles.
- Example: CLK_DIV=4, n=2 gives 1+4+2·129+8 = 271 cycles. `state_valid` pulses in the first GAP cycle.
- `mosi` changes only at the LOW entry, which is the falling-edge side. It is stable for the full HIGH phase.

## Structure
- Shared package `p18_spi_pkg` holds:
  - `P18_SPI_WORD_WIDTH`=16 and `P18_SPI_STATE_SIZE`=21, the same values the slave uses;
  - the FSM state typedef;
  - the command opcode constants shared with `p18_spi_ctrl`.
- Sub-module `p18_spi_div`: a CLK_DIV phase counter with a `tick` output on the last cycle of each phase. It is reset on every state change.
- Counter widths: phase counter $clog2(CLK_DIV), bit counter $clog2(WORD_WIDTH), capture counter $clog2(STATE_SIZE+1).

## Test plan
- **Reset**: hold `nRst`=0, then release → `ss`=1, `sck`=0, `busy`=0, `state_out`=0. No `sck` edges for 100 cycles.
- **Single word**: CLK_DIV=4, `word`=16'hA5C3, last=1 → `mosi` shows 1010010111000011 MSB-first on 16 rising edges. Return to IDLE 142 cycles after `start`. No `state_valid` pulse.
- **Two words with a `miso` model**: the model returns 21'h1ABCDE then zeros → `state_valid` pulses once with `state_out`=21'h1ABCDE. Total 271 cycles.
- **Stall**: drop `word_valid` for 50 cycles before the second word → `ss` stays 0 and `sck` stays 0 throughout. Transmission resumes correctly with total length +50.
- **Abort**: assert `nRst` low during bit 7 of word 1 → `ss`=1 and `sck`=0 within the same cycle. The following `start` runs a clean transaction.
- **Closed loop**: connect to a `p18_breakout` instance and send a line-write command → the slave's block line updates, and `state_out`[12:0] reflects the new line on the next read.

Source files
------------

// File: rtl/p18_spi_pkg.sv
// Shared definitions for the breakout SPI host and its controller.
package p18_spi_pkg;

    // Frame geometry, matched to the breakout slave.
    localparam int P18_SPI_WORD_WIDTH = 16;
    localparam int P18_SPI_STATE_SIZE = 21;

    // Host sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_FETCH,
        ST_LOW,
        ST_HIGH,
        ST_RELEASE,
        ST_GAP
    } p18_spi_state_e;

    // Command opcodes carried in the top nibble of a command word.
    localparam logic [3:0] P18_OP_NOP     = 4'h0;
    localparam logic [3:0] P18_OP_LINE_WR = 4'h1;
    localparam logic [3:0] P18_OP_READ    = 4'h2;
    localparam logic [3:0] P18_OP_RESET   = 4'h3;

    // Builds a command word from an opcode and a 12-bit payload.
    function automatic logic [P18_SPI_WORD_WIDTH-1:0] p18_make_cmd(
        input logic [3:0]  op,
        input logic [11:0] payload
    );
        return {op, payload};
    endfunction

endpackage

// File: rtl/p18_spi_div.sv
// Phase counter: ticks on the last clk of every CLK_DIV-cycle phase.
module p18_spi_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic nRst,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(CLK_DIV - 1));

    // Count phase cycles; restart at each FSM state change or phase wrap.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)                r_cnt <= '0;
        else if (i_clr || o_tick) r_cnt <= '0;
        else                      r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/p18_spi_host.sv
// SPI mode-0 host: frames words on ss, shifts MSB-first, captures a state snapshot.
module p18_spi_host
    import p18_spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int WORD_WIDTH = P18_SPI_WORD_WIDTH,
    parameter int STATE_SIZE = P18_SPI_STATE_SIZE
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  start,
    input  logic                  word_valid,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic                  word_last,
    output logic                  word_ready,
    output logic                  busy,
    output logic [STATE_SIZE-1:0] state_out,
    output logic                  state_valid,
    output logic                  sck,
    output logic                  ss,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int BW = $clog2(WORD_WIDTH);
    localparam int CW = $clog2(STATE_SIZE + 1);

    p18_spi_state_e          r_state;
    p18_spi_state_e          w_next;
    logic                    w_tick;
    logic                    w_state_chg;
    logic [WORD_WIDTH-1:0]   r_shift;
    logic [BW-1:0]           r_bit_cnt;
    logic                    r_last;
    logic [STATE_SIZE-1:0]   r_cap;
    logic [CW-1:0]           r_cap_cnt;
    logic [STATE_SIZE-1:0]   r_state_out;
    logic                    r_state_valid;

    assign w_state_chg = (w_next != r_state);

    p18_spi_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .nRst   (nRst),
        .i_clr  (w_state_chg),
        .o_tick (w_tick)
    );

    // Pin and status outputs are pure decodes of state, so reset reaches the pins at once.
    assign sck         = (r_state == ST_HIGH);
    assign ss          = (r_state == ST_IDLE) || (r_state == ST_GAP);
    assign mosi        = ((r_state == ST_LOW) || (r_state == ST_HIGH)) && r_shift[WORD_WIDTH-1];
    assign word_ready  = (r_state == ST_FETCH);
    assign busy        = (r_state != ST_IDLE);
    assign state_out   = r_state_out;
    assign state_valid = r_state_valid;

    // FSM state register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode; timed states advance on the phase tick.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start)      w_next = ST_ASSERT;
            ST_ASSERT:  if (w_tick)     w_next = ST_FETCH;
            ST_FETCH:   if (word_valid) w_next = ST_LOW;
            ST_LOW:     if (w_tick)     w_next = ST_HIGH;
            ST_HIGH: begin
                if (w_tick) begin
                    if (r_bit_cnt != '0) w_next = ST_LOW;
                    else if (r_last)     w_next = ST_RELEASE;
                    else                 w_next = ST_FETCH;
                end
            end
            ST_RELEASE: if (w_tick)     w_next = ST_GAP;
            ST_GAP:     if (w_tick)     w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    // Transmit shifter: load on handshake, advance after each HIGH phase so mosi moves on LOW entry.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_last    <= 1'b0;
        end else if (r_state == ST_FETCH && word_valid) begin
            r_shift   <= word;
            r_bit_cnt <= BW'(WORD_WIDTH - 1);
            r_last    <= word_last;
        end else if (r_state == ST_HIGH && w_tick && r_bit_cnt != '0) begin
            r_shift   <= r_shift << 1;
            r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

    // Capture the leading miso bits on the last HIGH cycle; the count saturates at STATE_SIZE.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_cap     <= '0;
            r_cap_cnt <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_cap_cnt <= '0;
        end else if (r_state == ST_HIGH && w_tick && r_cap_cnt < CW'(STATE_SIZE)) begin
            r_cap     <= {r_cap[STATE_SIZE-2:0], miso};
            r_cap_cnt <= r_cap_cnt + 1'b1;
        end
    end

    // Publish a complete snapshot when leaving RELEASE; short transactions leave it untouched.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state_out   <= '0;
            r_state_valid <= 1'b0;
        end else begin
            r_state_valid <= 1'b0;
            if (r_state == ST_RELEASE && w_tick && r_cap_cnt == CW'(STATE_SIZE)) begin
                r_state_out   <= r_cap;
                r_state_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_p18_spi_host.sv
// Directed bench for p18_spi_host with a pattern-returning miso model.
module tb_p18_spi_host;
    import p18_spi_pkg::*;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        start = 1'b0;
    logic        word_valid = 1'b0;
    logic [15:0] word = '0;
    logic        word_last = 1'b0;
    logic        miso;
    logic        word_ready, busy, state_valid, sck, ss, mosi;
    logic [20:0] state_out;

    p18_spi_host #(.CLK_DIV(4), .WORD_WIDTH(16), .STATE_SIZE(21)) dut (
        .clk(clk), .nRst(nRst), .start(start), .word_valid(word_valid),
        .word(word), .word_last(word_last), .word_ready(word_ready),
        .busy(busy), .state_out(state_out), .state_valid(state_valid),
        .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic        mon_clr = 1'b0;
    int          edges;
    logic [63:0] mosi_bits;
    int          sv_cnt;
    logic [20:0] pat = '0;
    logic [15:0] words [4];
    int          stall_bad;
    int          cyc;

    // Record mosi on every sck rising edge.
    always @(posedge sck or posedge mon_clr) begin
        if (mon_clr) begin
            edges     <= 0;
            mosi_bits <= '0;
        end else begin
            edges     <= edges + 1;
            mosi_bits <= {mosi_bits[62:0], mosi};
        end
    end

    // Count state_valid pulses.
    always @(posedge clk or posedge mon_clr) begin
        if (mon_clr)          sv_cnt <= 0;
        else if (state_valid) sv_cnt <= sv_cnt + 1;
    end

    // Slave model: bit k of the pattern (MSB first) is presented during the k-th HIGH phase.
    assign miso = (edges >= 1 && edges <= 21) ? pat[5'(21 - edges)] : 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        #1;
        mon_clr = 1'b0;
    endtask

    // Runs one transaction of nw words; stall holds word_valid low for that many FETCH cycles before later words.
    task automatic run_txn(input int nw, input int stall, output int cycles);
        int  idx;
        int  stall_left;
        logic acc;
        idx        = 0;
        stall_left = stall;
        stall_bad  = 0;
        word       = words[0];
        word_last  = (nw == 1);
        word_valid = 1'b1;
        start      = 1'b1;
        cycles     = 0;
        do begin
            acc = word_valid && word_ready;
            @(posedge clk);
            cycles++;
            @(negedge clk);
            start = 1'b0;
            if (acc) begin
                idx++;
                if (idx < nw) begin
                    word       = words[idx];
                    word_last  = (idx == nw - 1);
                    word_valid = (stall == 0);
                end else begin
                    word_valid = 1'b0;
                end
            end else if (!word_valid && idx < nw && word_ready) begin
                if (ss !== 1'b0 || sck !== 1'b0) stall_bad++;
                if (stall_left == 0) word_valid = 1'b1;
                else                 stall_left--;
            end
        end while (busy && cycles < 2000);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ss", 64'(ss), 64'd1);
        check("rst_sck", 64'(sck), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mosi", 64'(mosi), 64'd0);
        nRst = 1'b1;
        clr_mon();
        repeat (100) @(negedge clk);
        check("idle_ss", 64'(ss), 64'd1);
        check("idle_ready", 64'(word_ready), 64'd0);
        check("idle_sv", 64'(state_valid), 64'd0);
        check("idle_state_out", 64'(state_out), 64'd0);
        check("idle_sck_edges", 64'(edges), 64'd0);

        // Single word: 1+4+129+8 cycles, no snapshot
        words[0] = 16'hA5C3;
        pat      = 21'h1FFFFF;
        clr_mon();
        run_txn(1, 0, cyc);
        check("w1_cycles", 64'(cyc), 64'd142);
        check("w1_edges", 64'(edges), 64'd16);
        check("w1_mosi", 64'(mosi_bits[15:0]), 64'hA5C3);
        check("w1_sv_cnt", 64'(sv_cnt), 64'd0);
        check("w1_state_out", 64'(state_out), 64'd0);

        // Two words with snapshot returned on miso
        words[0] = 16'h1234;
        words[1] = 16'hBEEF;
        pat      = 21'h1ABCDE;
        clr_mon();
        run_txn(2, 0, cyc);
        check("w2_cycles", 64'(cyc), 64'd271);
        check("w2_edges", 64'(edges), 64'd32);
        check("w2_mosi", 64'(mosi_bits[31:0]), 64'h1234BEEF);
        check("w2_sv_cnt", 64'(sv_cnt), 64'd1);
        check("w2_state_out", 64'(state_out), 64'h1ABCDE);

        // Stall of 50 FETCH cycles before the second word
        words[0] = 16'hC0DE;
        words[1] = 16'h0F0F;
        pat      = 21'h0F00F5;
        clr_mon();
        run_txn(2, 50, cyc);
        check("stall_cycles", 64'(cyc), 64'd321);
        check("stall_pins", 64'(stall_bad), 64'd0);
        check("stall_mosi", 64'(mosi_bits[31:0]), 64'hC0DE0F0F);
        check("stall_sv_cnt", 64'(sv_cnt), 64'd1);
        check("stall_state_out", 64'(state_out), 64'h0F00F5);

        // Abort with reset during bit 7 of word 1
        pat = '0;
        clr_mon();
        word       = 16'h5A5A;
        word_last  = 1'b0;
        word_valid = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (edges < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_bit7", 64'(edges), 64'd8);
        check("abort_pre_sck", 64'(sck), 64'd1);
        #2;
        nRst = 1'b0;
        #1;
        check("abort_ss", 64'(ss), 64'd1);
        check("abort_sck", 64'(sck), 64'd0);
        check("abort_mosi", 64'(mosi), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_state_out", 64'(state_out), 64'd0);
        word_valid = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);

        // Clean transaction after the abort
        words[0] = 16'h3C96;
        clr_mon();
        run_txn(1, 0, cyc);
        check("post_cycles", 64'(cyc), 64'd142);
        check("post_edges", 64'(edges), 64'd16);
        check("post_mosi", 64'(mosi_bits[15:0]), 64'h3C96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
